// File: rtl/address_mapper_pkg.sv
// Fixed-point constants shared by the pixel-to-complex-plane address mapper.
// All values are derived from the fraction width so every file agrees on them.
package address_mapper_pkg;

   localparam int COORD_W = 32;

   typedef logic signed [COORD_W-1:0] coord_t;

   // Real axis starts at -2.0 and spans 3.0 across one row.
   function automatic coord_t x_origin(input int fp);
      return coord_t'(-(2 << fp));
   endfunction

   function automatic coord_t x_step(input int fp, input int max_x);
      return coord_t'((3 << fp) / max_x);
   endfunction

   // Imaginary axis starts at +1.125 and spans 2.25 down the frame.
   function automatic coord_t y_origin(input int fp);
      return coord_t'(9 << (fp - 3));
   endfunction

   function automatic coord_t y_step(input int fp, input int max_y);
      return coord_t'((9 << (fp - 2)) / max_y);
   endfunction

endpackage

// File: rtl/address_mapper_axis_stepper.sv
// One scan axis: position counter plus fixed-point coordinate accumulator.
// Advances only when en is high and reloads the origin on its last position.
module axis_stepper
   import address_mapper_pkg::*;
#(
   parameter int     COUNT_MAX = 64,
   parameter coord_t ORIGIN    = '0,
   parameter coord_t STEP      = '0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   output coord_t coord,
   output logic   wrap
);

   localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_MAX - 1);

   logic [CNT_W-1:0] count;
   logic             at_last;

   assign at_last = (count == LAST);
   assign wrap    = en && at_last;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         coord <= ORIGIN;
      end else if (en) begin
         if (at_last) begin
            count <= '0;
            coord <= ORIGIN;
         end else begin
            count <= count + 1'b1;
            coord <= coord + STEP;
         end
      end
   end

endmodule

// File: rtl/address_mapper.sv
// Raster-scans a MAX_X x MAX_Y frame, one pixel per clock, emitting each
// pixel's complex-plane coordinate as signed fixed point.
module address_mapper
   import address_mapper_pkg::*;
#(
   parameter int FLOAT_PRECISION = 24,
   parameter int MAX_X           = 64,
   parameter int MAX_Y           = 48
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic signed [COORD_W-1:0] mapped_x,
   output logic signed [COORD_W-1:0] mapped_y
);

   localparam coord_t X_ORIGIN = x_origin(FLOAT_PRECISION);
   localparam coord_t X_STEP   = x_step(FLOAT_PRECISION, MAX_X);
   localparam coord_t Y_ORIGIN = y_origin(FLOAT_PRECISION);
   localparam coord_t Y_STEP   = y_step(FLOAT_PRECISION, MAX_Y);

   logic row_wrap;
   logic unused_frame_wrap;

   axis_stepper #(
      .COUNT_MAX (MAX_X),
      .ORIGIN    (X_ORIGIN),
      .STEP      (X_STEP)
   ) u_x_axis (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .coord (mapped_x),
      .wrap  (row_wrap)
   );

   // Rows advance downward, so the y accumulator steps by a negative amount.
   axis_stepper #(
      .COUNT_MAX (MAX_Y),
      .ORIGIN    (Y_ORIGIN),
      .STEP      (-Y_STEP)
   ) u_y_axis (
      .clk   (clk),
      .rst   (rst),
      .en    (row_wrap),
      .coord (mapped_y),
      .wrap  (unused_frame_wrap)
   );

endmodule

// File: tb/tb_address_mapper.sv
// Self-checking bench for address_mapper: per-cycle scoreboard against a
// multiply-based coordinate model plus a table of fixed landmark pixels.
module tb_address_mapper;

   localparam int FP = 24;
   localparam int MX = 64;
   localparam int MY = 48;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic signed [31:0] mapped_x;
   logic signed [31:0] mapped_y;

   address_mapper #(
      .FLOAT_PRECISION (FP),
      .MAX_X           (MX),
      .MAX_Y           (MY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mapped_x (mapped_x),
      .mapped_y (mapped_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
   } exp_t;

   typedef struct {
      int cyc;
      int x;
      int y;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[10];

   int px_m   = 0;
   int py_m   = 0;
   int edge_n = 0;
   int n_checks = 0;
   int n_pass   = 0;

   function automatic int model_x(input int px);
      return -(2 << FP) + px * ((3 << FP) / MX);
   endfunction

   function automatic int model_y(input int py);
      return (9 << (FP - 3)) - py * ((9 << (FP - 2)) / MY);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Drive rst for one edge, predict the result, then compare after the edge.
   task automatic step(input bit r);
      exp_t e;
      @(negedge clk);
      rst = r;
      if (!r) begin
         px_m = 0;
         py_m = 0;
         edge_n = 0;
      end else begin
         edge_n++;
         if (px_m == MX - 1) begin
            px_m = 0;
            py_m = (py_m == MY - 1) ? 0 : py_m + 1;
         end else begin
            px_m++;
         end
      end
      exp_q.push_back('{x: model_x(px_m), y: model_y(py_m)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("model_x edge %0d rst %0b", edge_n, r), mapped_x, e.x);
      check($sformatf("model_y edge %0d rst %0b", edge_n, r), mapped_y, e.y);
      if (r) begin
         for (int i = 0; i < 10; i++) begin
            if (vecs[i].cyc == edge_n) begin
               check($sformatf("vec_x edge %0d", edge_n), mapped_x, vecs[i].x);
               check($sformatf("vec_y edge %0d", edge_n), mapped_y, vecs[i].y);
            end
         end
      end else begin
         check("reset_x", mapped_x, -33554432);
         check("reset_y", mapped_y, 18874368);
      end
   endtask

   initial begin
      vecs[0] = '{cyc: 1,    x: -32768000, y: 18874368};
      vecs[1] = '{cyc: 2,    x: -31981568, y: 18874368};
      vecs[2] = '{cyc: 3,    x: -31195136, y: 18874368};
      vecs[3] = '{cyc: 63,   x: 15990784,  y: 18874368};
      vecs[4] = '{cyc: 64,   x: -33554432, y: 18087936};
      vecs[5] = '{cyc: 3071, x: 15990784,  y: -18087936};
      vecs[6] = '{cyc: 3072, x: -33554432, y: 18874368};
      vecs[7] = '{cyc: 3073, x: -32768000, y: 18874368};
      vecs[8] = '{cyc: 3135, x: 15990784,  y: 18874368};
      vecs[9] = '{cyc: 6143, x: 15990784,  y: -18087936};

      // Reset held for three edges.
      for (int i = 0; i < 3; i++) step(1'b0);

      // Two full frames plus a few pixels of the third.
      for (int i = 0; i < 2 * MX * MY + 8; i++) step(1'b1);

      // Mid-frame reset: scan to edge 999, reset for one edge, then resume.
      step(1'b0);
      for (int i = 0; i < 999; i++) step(1'b1);
      step(1'b0);
      for (int i = 0; i < 70; i++) step(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/address_mapper.md
ADDRESS_MAPPER -- requirements
Module: address_mapper

Interface
REQ-001 SHALL have parameter FLOAT_PRECISION, default 24, number of fractional bits in both outputs.
REQ-002 SHALL have parameter MAX_X, default 64, pixels per row.
REQ-003 SHALL have parameter MAX_Y, default 48, rows per frame.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit; reset rst, synchronous, active-low; clock clk.
REQ-006 SHALL have port mapped_x, output, signed 32 bits, real-axis coordinate of current pixel, two's-complement fixed point with FLOAT_PRECISION fraction bits.
REQ-007 SHALL have port mapped_y, output, signed 32 bits, imaginary-axis coordinate of current pixel, same format.

Function
REQ-008 SHALL scan pixels in raster order, one pixel per clk cycle, no stalls, no inputs besides clk/rst.
REQ-009 SHALL keep internal counters px in 0..MAX_X-1 and py in 0..MAX_Y-1.
REQ-010 SHALL map the frame onto the rectangle real [-2.0, 1.0), imaginary (-1.125, 1.125].
REQ-011 SHALL define X_STEP = (3 << FLOAT_PRECISION) / MAX_X and Y_STEP = (9 << (FLOAT_PRECISION-2)) / MAX_Y, integer-truncated; defaults both 786432 (0.046875).
REQ-012 SHALL output mapped_x = -(2 << FLOAT_PRECISION) + px*X_STEP and mapped_y = (9 << (FLOAT_PRECISION-3)) - py*Y_STEP, both registered.
REQ-013 SHALL compute coordinates by incremental add/subtract of the step constants, no multipliers; result bit-exact to REQ-012.
REQ-014 SHALL, each cycle with px < MAX_X-1, increment px and add X_STEP to mapped_x; mapped_y unchanged.
REQ-015 SHALL, at px = MAX_X-1 and py < MAX_Y-1, wrap px to 0, reload mapped_x to -2.0, increment py, subtract Y_STEP from mapped_y, in the same cycle.
REQ-016 SHALL, at px = MAX_X-1 and py = MAX_Y-1, wrap both counters to 0 and reload (-2.0, 1.125); frame period MAX_X*MAX_Y cycles, repeating indefinitely.
REQ-017 SHALL keep all arithmetic in 32-bit signed; no overflow possible for FLOAT_PRECISION <= 28.

Reset
REQ-018 SHALL, on any rising clk edge with rst = 0, set px = 0, py = 0, mapped_x = -(2 << FLOAT_PRECISION), mapped_y = 9 << (FLOAT_PRECISION-3) (defaults -33554432, 18874368).
REQ-019 SHALL hold reset values while rst = 0; first edge with rst = 1 advances to pixel (1,0).
REQ-020 SHALL, on reset asserted mid-frame, abandon the frame and restart at pixel (0,0) with no residual state.

Structure
REQ-021 SHALL place FLOAT_PRECISION-derived constants (origin values, X_STEP, Y_STEP, coordinate width 32) in a shared package address_mapper_pkg.
REQ-022 SHALL use one sub-module axis_stepper (counter + fixed-point accumulator with wrap output and carry-in enable), instantiated once per axis; the y instance enabled by the x instance's wrap.

Verification
REQ-023 Reset held 3 cycles -> outputs (-2.0, 1.125) = (-33554432, 18874368) every cycle.
REQ-024 Release reset, sample edges 1..3 -> mapped_x -1.953125, -1.90625, -1.859375; mapped_y 1.125 constant.
REQ-025 Edge 63 after release -> (0.953125, 1.125); edge 64 -> (-2.0, 1.078125).
REQ-026 Edge 3071 -> (0.953125, -1.078125); edge 3072 -> (-2.0, 1.125); second frame identical to first.
REQ-027 Assert rst at edge 1000 for 1 cycle -> next output (-2.0, 1.125), then scan resumes as REQ-024.
REQ-028 Bench checks every cycle against REQ-012 model, raw integers, exact match.
